// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Brief   : RV32I load/store front end to a byte-addressed, word-wide memory;
//           sub-word stores are built as read-modify-write.
// Revision: 1.0
// ============================================================================
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 1024
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_op,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_w,
  input  logic [DATA_WIDTH-1:0] mem_data_r
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE_RD, STORE_WR} state_t;

  state_t                state_q, state_d;
  logic                  mem_op_q, mem_op_d;
  logic                  mem_rw_q, mem_rw_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_w_q, mem_data_w_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  err_pend_q, err_pend_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  accept;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] load_ext;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;

  // Mem always touches four bytes, so the last legal start address is MEM_SIZE-4.
  assign misaligned   = ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                        ((req_funct3[1:0] == 2'b01) && req_addr[0]);
  assign out_of_range = req_addr > ADDR_WIDTH'(MEM_SIZE - 4);
  assign illegal      = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                               : ((req_funct3[1:0] == 2'b11) || (req_funct3[2:1] == 2'b11));

  always_comb begin
    load_ext = mem_data_r;
    case (funct3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){mem_data_r[7]}}, mem_data_r[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){mem_data_r[15]}}, mem_data_r[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, mem_data_r[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, mem_data_r[15:0]};
      default: load_ext = mem_data_r;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_op_d     = mem_op_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_data_w_d = mem_data_w_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    err_pend_d   = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;

    // A rejected request answers one cycle after acceptance without leaving IDLE.
    if (err_pend_q) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misaligned || out_of_range || illegal) begin
            err_pend_d = 1'b1;
          end else begin
            mem_op_d   = 1'b1;
            mem_addr_d = req_addr;
            funct3_d   = req_funct3;
            wdata_d    = req_wdata[15:0];
            if (!req_we) begin
              mem_rw_d = 1'b0;
              state_d  = LOAD;
            end else if (req_funct3[1:0] == 2'b10) begin
              mem_rw_d     = 1'b1;
              mem_data_w_d = req_wdata;
              state_d      = STORE_WR;
            end else begin
              mem_rw_d = 1'b0;
              state_d  = STORE_RD;
            end
          end
        end
      end
      LOAD: begin
        mem_op_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_ext;
        state_d     = IDLE;
      end
      STORE_RD: begin
        mem_rw_d     = 1'b1;
        mem_data_w_d = funct3_q[0] ? {mem_data_r[DATA_WIDTH-1:16], wdata_q}
                                   : {mem_data_r[DATA_WIDTH-1:8], wdata_q[7:0]};
        state_d      = STORE_WR;
      end
      STORE_WR: begin
        mem_op_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      mem_op_q     <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_w_q <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      err_pend_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      mem_op_q     <= mem_op_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_w_q <= mem_data_w_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      err_pend_q   <= err_pend_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign mem_op     = mem_op_q;
  assign mem_rw     = mem_rw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data_w = mem_data_w_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_load_store_unit
// Brief   : Scoreboard bench for load_store_unit with a byte-array Mem model
//           and a byte-level reference model of RV32I load/store semantics.
// Revision: 1.0
// ============================================================================
module tb_load_store_unit;

  localparam int MEM_SIZE = 1024;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_op;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_w;
  logic [31:0] mem_data_r = 32'd0;

  load_store_unit #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_SIZE  (MEM_SIZE)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_op    (mem_op),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_data_w(mem_data_w),
    .mem_data_r(mem_data_r)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Mem device: byte array, four bytes little-endian from addr, acts on negedge.
  logic [7:0] mem_b [0:MEM_SIZE-1];
  always @(negedge sys_clk) begin
    if (mem_op && (mem_addr <= 32'(MEM_SIZE - 4))) begin
      if (!mem_rw)
        mem_data_r <= {mem_b[mem_addr+3], mem_b[mem_addr+2], mem_b[mem_addr+1], mem_b[mem_addr]};
      else begin
        mem_b[mem_addr]   <= mem_data_w[7:0];
        mem_b[mem_addr+1] <= mem_data_w[15:8];
        mem_b[mem_addr+2] <= mem_data_w[23:16];
        mem_b[mem_addr+3] <= mem_data_w[31:24];
      end
    end
  end

  // Reference model: architectural byte memory updated at issue time.
  logic [7:0] ref_b [0:MEM_SIZE-1];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
    int          lat;
    int          ops;
  } exp_t;

  exp_t sbq[$];

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output exp_t e);
    int unsigned ai;
    int          nb;
    logic        ill;
    logic [31:0] w;
    int          sv;
    ai = a;
    if (we) ill = !(f3 inside {3'd0, 3'd1, 3'd2});
    else    ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nb = (f3 == 3'd0 || f3 == 3'd4) ? 1 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 4);
    e.err   = ill || (ai > MEM_SIZE - 4) || ((ai % nb) != 0);
    e.rdata = 32'd0;
    e.ops   = 0;
    e.lat   = 1;
    e.acc   = 0;
    if (!e.err) begin
      if (!we) begin
        w = {ref_b[ai+3], ref_b[ai+2], ref_b[ai+1], ref_b[ai]};
        e.ops = 1;
        case (f3)
          3'd0:    begin sv = $signed(w[7:0]);  e.rdata = sv; end
          3'd1:    begin sv = $signed(w[15:0]); e.rdata = sv; end
          3'd4:    e.rdata = {24'd0, w[7:0]};
          3'd5:    e.rdata = {16'd0, w[15:0]};
          default: e.rdata = w;
        endcase
      end else begin
        for (int i = 0; i < nb; i++) ref_b[ai+i] = wd[8*i +: 8];
        e.ops = (nb == 4) ? 1 : 2;
        e.lat = (nb == 4) ? 1 : 2;
      end
    end
  endtask

  // Driver: inputs change on negedge; request is accepted at the next posedge with req_ready high.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   n;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    end else begin
      model(we, f3, a, wd, e);
      e.acc = cyc + 1;
      sbq.push_back(e);
    end
    @(negedge sys_clk);
    req_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per rsp_valid; counts Mem ops since the last response.
  int op_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        op_cnt = 0;
        chk("rsp_valid_in_reset", {31'd0, rsp_valid}, 32'd0);
      end else begin
        if (rsp_valid) begin
          if (sbq.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
            chk("mem_op_cycles", 32'(op_cnt), 32'(e.ops));
          end
          op_cnt = 0;
        end
        if (mem_op) op_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk("drain_pending", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    logic [7:0]  b;
    int          r;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int i = 0; i < MEM_SIZE; i++) begin
      b = 8'($urandom);
      mem_b[i] = b;
      ref_b[i] = b;
    end
    {mem_b[3], mem_b[2], mem_b[1], mem_b[0]}         = 32'h0010_0513;
    {ref_b[3], ref_b[2], ref_b[1], ref_b[0]}         = 32'h0010_0513;
    {mem_b[35], mem_b[34], mem_b[33], mem_b[32]}     = 32'h1122_3344;
    {ref_b[35], ref_b[34], ref_b[33], ref_b[32]}     = 32'h1122_3344;

    repeat (3) @(negedge sys_clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_mem_op", {31'd0, mem_op}, 32'd0);
    chk("reset_mem_rw", {31'd0, mem_rw}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_data_w", mem_data_w, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    issue(1'b0, 3'b010, 32'h000, 32'h0);
    issue(1'b1, 3'b000, 32'h020, 32'hAABB_CCDD);
    issue(1'b0, 3'b010, 32'h020, 32'h0);
    issue(1'b0, 3'b000, 32'h020, 32'h0);
    issue(1'b0, 3'b100, 32'h020, 32'h0);
    issue(1'b0, 3'b001, 32'h022, 32'h0);
    issue(1'b1, 3'b001, 32'h022, 32'h0000_BEEF);
    issue(1'b0, 3'b010, 32'h020, 32'h0);
    issue(1'b0, 3'b010, 32'h022, 32'h0);
    issue(1'b0, 3'b001, 32'h021, 32'h0);
    issue(1'b0, 3'b000, 32'h3FE, 32'h0);
    issue(1'b0, 3'b011, 32'h000, 32'h0);
    issue(1'b0, 3'b010, 32'h3FC, 32'h0);
    issue(1'b1, 3'b000, 32'h030, 32'h1234_5680);
    issue(1'b0, 3'b010, 32'h030, 32'h0);
    issue(1'b1, 3'b010, 32'h034, 32'hCAFE_F00D);
    drain();

    // Reset during the read phase of an SB must abort without a response or a write.
    @(negedge sys_clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h040;
    req_wdata  = 32'h0000_0055;
    @(posedge sys_clk);
    #1;
    req_valid = 1'b0;
    chk("abort_pre_mem_op", {31'd0, mem_op}, 32'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("abort_mem_op", {31'd0, mem_op}, 32'd0);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    issue(1'b0, 3'b010, 32'h040, 32'h0);
    drain();

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = 32'($urandom_range(0, 63));
      else if (r < 9) a = 32'($urandom_range(MEM_SIZE - 8, MEM_SIZE + 3));
      else            a = $urandom;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we)                   f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      issue(we, f3, a, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge sys_clk);
    end
    drain();
    repeat (3) @(negedge sys_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
